// File: rtl/count_monitor_pkg.sv
// rtl/count_monitor_pkg.sv - shared types for the count monitor and its event buffer
package count_monitor_pkg;

    typedef enum logic [1:0] {
        EVT_NONE    = 2'b00,
        EVT_WRAP    = 2'b01,
        EVT_RESTART = 2'b10,
        EVT_ERROR   = 2'b11
    } evt_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_RESYNC = 2'b10
    } fsm_state_e;

    typedef struct packed {
        evt_kind_e   kind;
        logic [3:0]  value;
        logic [7:0]  cycles;
    } evt_rec_t;

endpackage

// File: rtl/count_monitor_if.sv
// rtl/count_monitor_if.sv - event record stream between the monitor and its consumer
interface count_monitor_if;

    logic        evt_valid;
    logic        evt_ready;
    logic [1:0]  evt_kind;
    logic [3:0]  evt_value;
    logic [7:0]  evt_cycles;

    modport master (
        output evt_valid,
        output evt_kind,
        output evt_value,
        output evt_cycles,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_kind,
        input  evt_value,
        input  evt_cycles,
        output evt_ready
    );

endinterface

// File: rtl/count_evt_fifo.sv
// rtl/count_evt_fifo.sv - power-of-two event record buffer with valid/ready pop
module count_evt_fifo
    import count_monitor_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  evt_rec_t push_data,
    output logic     full,
    output logic     out_valid,
    input  logic     out_ready,
    output evt_rec_t out_data
);

    localparam int AW = $clog2(DEPTH);

    evt_rec_t       mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_pop;
    logic           do_push;

    assign full      = (count == (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign do_pop    = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts the push.
    assign do_push   = push && (!full || do_pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/count_monitor.sv
// rtl/count_monitor.sv - checks an upstream modulo counter and queues wrap/restart/error events
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int MOD        = 15,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            count_in,
    input  logic                  count_valid,
    count_monitor_if.master       evt,
    output logic [7:0]            wraps,
    output logic                  overflow
);

    localparam logic [4:0] MOD_M1 = 5'(MOD - 1);

    fsm_state_e  state;
    logic [3:0]  last;
    logic        last_is_top;
    logic        is_step;
    logic        gen;
    evt_kind_e   gen_kind;
    evt_rec_t    push_rec;
    evt_rec_t    head;
    logic        fifo_full;

    // Widened to 5 bits so last+1 cannot alias back to 0 when MOD is 16.
    assign last_is_top = ({1'b0, last} == MOD_M1);
    assign is_step     = ({1'b0, count_in} == ({1'b0, last} + 5'd1)) && ({1'b0, last} < MOD_M1);

    always_comb begin
        gen      = 1'b0;
        gen_kind = EVT_NONE;
        if (count_valid && state == ST_TRACK) begin
            if (count_in == 4'd0 && last_is_top) begin
                gen      = 1'b1;
                gen_kind = EVT_WRAP;
            end else if (count_in == 4'd0) begin
                gen      = 1'b1;
                gen_kind = EVT_RESTART;
            end else if (!is_step) begin
                gen      = 1'b1;
                gen_kind = EVT_ERROR;
            end
        end
    end

    assign push_rec.kind   = gen_kind;
    assign push_rec.value  = count_in;
    assign push_rec.cycles = (gen_kind == EVT_WRAP) ? wraps + 8'd1 : wraps;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            last     <= 4'd0;
            wraps    <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (count_valid) begin
                last <= count_in;
                case (state)
                    ST_IDLE, ST_RESYNC: state <= ST_TRACK;
                    ST_TRACK: begin
                        if (gen && gen_kind == EVT_ERROR) begin
                            state <= ST_RESYNC;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
                if (gen && gen_kind == EVT_WRAP) begin
                    wraps <= wraps + 8'd1;
                end
            end
            // Full implies evt_valid, so only a missing ready loses the record.
            if (gen && fifo_full && !evt.evt_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    count_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (gen),
        .push_data (push_rec),
        .full      (fifo_full),
        .out_valid (evt.evt_valid),
        .out_ready (evt.evt_ready),
        .out_data  (head)
    );

    assign evt.evt_kind   = head.kind;
    assign evt.evt_value  = head.value;
    assign evt.evt_cycles = head.cycles;

endmodule

// File: tb/tb_count_monitor.sv
// tb/tb_count_monitor.sv - directed and randomized bench with a behavioural event model
module tb_count_monitor;

    localparam int MOD   = 15;
    localparam int DEPTH = 2;

    typedef struct {
        int kind;
        int value;
        int cycles;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        count_valid = 1'b0;
    logic [3:0]  count_in = 4'd0;
    logic [7:0]  wraps;
    logic        overflow;

    count_monitor_if evt ();

    count_monitor #(
        .MOD        (MOD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .evt         (evt),
        .wraps       (wraps),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    bit   m_base;
    int   m_last;
    int   m_wraps;
    bit   m_ovf;
    ev_t  q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_base  = 1'b0;
        m_last  = 0;
        m_wraps = 0;
        m_ovf   = 1'b0;
        q.delete();
    endtask

    task automatic model_edge(input bit v, input int c, input bit rdy);
        bit  pop;
        bit  emit;
        ev_t e;
        pop  = rdy && (q.size() > 0);
        emit = 1'b0;
        e    = '{0, 0, 0};
        if (v) begin
            if (!m_base) begin
                m_base = 1'b1;
            end else if (c == 0 && m_last == MOD - 1) begin
                m_wraps = (m_wraps + 1) % 256;
                emit = 1'b1;
                e.kind = 1;
            end else if (c == 0) begin
                emit = 1'b1;
                e.kind = 2;
            end else if (!(c == m_last + 1 && c < MOD)) begin
                emit = 1'b1;
                e.kind = 3;
                m_base = 1'b0;
            end
            e.value  = c;
            e.cycles = m_wraps;
            m_last   = c;
        end
        if (pop) void'(q.pop_front());
        if (emit) begin
            if (q.size() < DEPTH) q.push_back(e);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        ev_t h;
        h = '{0, 0, 0};
        if (q.size() > 0) h = q[0];
        chk({tag, ".valid"},    32'(evt.evt_valid),  32'(q.size() > 0));
        chk({tag, ".kind"},     32'(evt.evt_kind),   32'(h.kind));
        chk({tag, ".value"},    32'(evt.evt_value),  32'(h.value));
        chk({tag, ".cycles"},   32'(evt.evt_cycles), 32'(h.cycles));
        chk({tag, ".wraps"},    32'(wraps),          32'(m_wraps));
        chk({tag, ".overflow"}, 32'(overflow),       32'(m_ovf));
    endtask

    task automatic step(input string tag, input bit v, input int c, input bit rdy);
        count_valid   = v;
        count_in      = 4'(c);
        evt.evt_ready = rdy;
        @(posedge clk);
        model_edge(v, c, rdy);
        @(negedge clk);
        compare_all(tag);
    endtask

    initial begin
        evt.evt_ready = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // one full lap and a wrap
        for (int c = 0; c < MOD; c++) step("lap", 1'b1, c, 1'b1);
        step("wrap", 1'b1, 0, 1'b1);
        chk("wrap.kind_const",   32'(evt.evt_kind),   32'd1);
        chk("wrap.value_const",  32'(evt.evt_value),  32'd0);
        chk("wrap.cycles_const", 32'(evt.evt_cycles), 32'd1);
        chk("wrap.wraps_const",  32'(wraps),          32'd1);

        // early return to zero
        for (int c = 1; c <= 4; c++) step("pre_restart", 1'b1, c, 1'b1);
        step("restart", 1'b1, 0, 1'b1);
        chk("restart.kind_const",  32'(evt.evt_kind),  32'd2);
        chk("restart.wraps_const", 32'(wraps),         32'd1);

        // skip 5 -> 7 then resync on 8, track on 9
        for (int c = 1; c <= 5; c++) step("pre_err", 1'b1, c, 1'b1);
        step("err7", 1'b1, 7, 1'b1);
        chk("err7.kind_const",  32'(evt.evt_kind),  32'd3);
        chk("err7.value_const", 32'(evt.evt_value), 32'd7);
        step("resync8", 1'b1, 8, 1'b1);
        step("track9",  1'b1, 9, 1'b1);
        chk("track9.no_evt", 32'(evt.evt_valid), 32'd0);

        // stalled consumer: ERROR, RESTART, then a dropped ERROR
        step("ovf_err1",  1'b1, 3, 1'b0);
        step("ovf_base",  1'b1, 5, 1'b0);
        step("ovf_rst",   1'b1, 0, 1'b0);
        step("ovf_err2",  1'b1, 2, 1'b0);
        chk("ovf.flag_const", 32'(overflow),       32'd1);
        chk("ovf.head_kind",  32'(evt.evt_kind),   32'd3);
        chk("ovf.head_value", 32'(evt.evt_value),  32'd3);
        step("drain1", 1'b0, 0, 1'b1);
        chk("drain1.kind_const", 32'(evt.evt_kind), 32'd2);
        step("drain2", 1'b0, 0, 1'b1);
        chk("drain2.empty", 32'(evt.evt_valid), 32'd0);

        // randomized traffic with a mostly-stepping counter
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit rdy;
            int c;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) != 0) c = (m_last + 1) % MOD;
            else c = int'($urandom_range(0, 15));
            step("rand", v, c, rdy);
        end

        // async reset between edges with a record pending
        step("pre_rst_base", 1'b1, 4, 1'b0);
        step("pre_rst_err",  1'b1, 9, 1'b0);
        step("pre_rst_err2", 1'b1, 1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("async.valid",    32'(evt.evt_valid), 32'd0);
        chk("async.wraps",    32'(wraps),         32'd0);
        chk("async.overflow", 32'(overflow),      32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("post_rst6", 1'b1, 6, 1'b1);
        chk("post_rst6.no_evt", 32'(evt.evt_valid), 32'd0);

        // gaps in count_valid across a wrap
        for (int c = 7; c <= 12; c++) step("gap_pre", 1'b1, c, 1'b1);
        step("gap13", 1'b1, 13, 1'b1);
        step("gap_x", 1'b0, 2, 1'b1);
        step("gap14", 1'b1, 14, 1'b1);
        step("gap_y", 1'b0, 5, 1'b1);
        step("gap0",  1'b1, 0, 1'b1);
        chk("gap.kind_const",  32'(evt.evt_kind), 32'd1);
        chk("gap.wraps_const", 32'(wraps),        32'd1);

        // run the wrap counter through 255 -> 0
        for (int w = 0; w < 255; w++) begin
            for (int c = 1; c < MOD; c++) step("roll", 1'b1, c, 1'b1);
            step("roll_wrap", 1'b1, 0, 1'b1);
        end
        chk("roll.wraps_zero",  32'(wraps),           32'd0);
        chk("roll.cycles_zero", 32'(evt.evt_cycles),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
